// File: rtl/lda_avalon_ctrl_pkg.sv
// Shared definitions for the line drawing engine's Avalon-MM front end:
// register map, handshake FSM encoding and START/END field positions.
package lda_avalon_ctrl_pkg;

    localparam logic [2:0] ADDR_MODE    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_GO      = 3'd2;
    localparam logic [2:0] ADDR_START   = 3'd3;
    localparam logic [2:0] ADDR_END     = 3'd4;
    localparam logic [2:0] ADDR_COLOUR  = 3'd5;
    localparam logic [2:0] ADDR_LINECNT = 3'd6;

    // START/END pack X in the low bits and Y directly above it
    localparam int FIELD_X_LSB = 0;
    localparam int FIELD_Y_LSB = 9;

    localparam int LINECNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/lda_handshake_fsm.sv
// Go/done handshake with the line engine: raises go until done, then waits
// for done to drop before accepting another line.
module lda_handshake_fsm
    import lda_avalon_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_start,
    input  logic   i_done,
    output logic   o_go,
    output logic   o_busy,
    output logic   o_line_done,
    output state_t o_state
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_next = ST_RUN;
            ST_RUN:     if (i_done)  w_next = ST_RELEASE;
            ST_RELEASE: if (!i_done) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // done is ignored in IDLE, so a stuck-high done only shortens RUN to one cycle
    always_comb begin
        o_go        = (r_state == ST_RUN);
        o_busy      = (r_state != ST_IDLE);
        o_line_done = (r_state == ST_RUN) && i_done;
        o_state     = r_state;
    end

endmodule

// File: rtl/lda_avalon_ctrl.sv
// Avalon-MM slave holding line endpoints/colour; a GO write starts the engine.
// Valid/ready: a write completes on the cycle chipselect&write is high with waitrequest low; reads never stall.
module lda_avalon_ctrl
    import lda_avalon_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                waitrequest,
    output logic                lda_go,
    input  logic                lda_done,
    output logic [X_W-1:0]      lda_x0,
    output logic [X_W-1:0]      lda_x1,
    output logic [Y_W-1:0]      lda_y0,
    output logic [Y_W-1:0]      lda_y1,
    output logic [COLOUR_W-1:0] lda_colour,
    output state_t              o_dbg_state
);

    logic                 r_mode;
    logic [X_W-1:0]       r_x0;
    logic [X_W-1:0]       r_x1;
    logic [Y_W-1:0]       r_y0;
    logic [Y_W-1:0]       r_y1;
    logic [COLOUR_W-1:0]  r_colour;
    logic [LINECNT_W-1:0] r_linecnt;
    logic                 r_go_pending;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_go_wr;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_busy;
    logic                 w_line_done;
    logic [DATA_W-1:0]    w_rdata;
    logic                 w_unused;

    assign w_wr     = chipselect & write;
    assign w_rd     = chipselect & read & ~write;
    assign w_go_wr  = w_wr && (address == ADDR_GO);
    assign w_accept = w_wr && !w_busy;
    // A stall-mode GO is still held by the master when the FSM returns to IDLE;
    // r_go_pending lets that same access complete without starting a second line.
    assign w_start  = w_go_wr && !w_busy && !r_go_pending;

    assign waitrequest = w_wr && (w_busy || (w_start && !r_mode));

    lda_handshake_fsm u_fsm (
        .clk         (clock),
        .rst         (reset),
        .i_start     (w_start),
        .i_done      (lda_done),
        .o_go        (lda_go),
        .o_busy      (w_busy),
        .o_line_done (w_line_done),
        .o_state     (o_dbg_state)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_go_pending <= 1'b0;
        end else if (w_start && !r_mode) begin
            r_go_pending <= 1'b1;
        end else if (!w_busy) begin
            r_go_pending <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode    <= 1'b0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_colour  <= '0;
            r_linecnt <= '0;
        end else if (w_line_done) begin
            r_linecnt <= r_linecnt + LINECNT_W'(1);
        end else if (w_accept) begin
            case (address)
                ADDR_MODE:    r_mode <= writedata[0];
                ADDR_START: begin
                    r_x0 <= writedata[FIELD_X_LSB +: X_W];
                    r_y0 <= writedata[FIELD_Y_LSB +: Y_W];
                end
                ADDR_END: begin
                    r_x1 <= writedata[FIELD_X_LSB +: X_W];
                    r_y1 <= writedata[FIELD_Y_LSB +: Y_W];
                end
                ADDR_COLOUR:  r_colour  <= writedata[COLOUR_W-1:0];
                ADDR_LINECNT: r_linecnt <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_MODE:   w_rdata[0] = r_mode;
            ADDR_STATUS: w_rdata[0] = w_busy;
            ADDR_START: begin
                w_rdata[FIELD_X_LSB +: X_W] = r_x0;
                w_rdata[FIELD_Y_LSB +: Y_W] = r_y0;
            end
            ADDR_END: begin
                w_rdata[FIELD_X_LSB +: X_W] = r_x1;
                w_rdata[FIELD_Y_LSB +: Y_W] = r_y1;
            end
            ADDR_COLOUR:  w_rdata[COLOUR_W-1:0]  = r_colour;
            ADDR_LINECNT: w_rdata[LINECNT_W-1:0] = r_linecnt;
            default: ;
        endcase
    end

    assign readdata   = w_rd ? w_rdata : '0;
    assign lda_x0     = r_x0;
    assign lda_x1     = r_x1;
    assign lda_y0     = r_y0;
    assign lda_y1     = r_y1;
    assign lda_colour = r_colour;
    assign w_unused   = ^writedata[DATA_W-1:FIELD_Y_LSB+Y_W];

endmodule

// File: tb/tb_lda_avalon_ctrl.sv
// Bench for lda_avalon_ctrl: bus driver tasks, an engine model that checks each
// started line against queued endpoints, and a register model for readback.
module tb_lda_avalon_ctrl;
    import lda_avalon_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        lda_go;
    logic        lda_done;
    logic [8:0]  lda_x0;
    logic [8:0]  lda_x1;
    logic [7:0]  lda_y0;
    logic [7:0]  lda_y1;
    logic [2:0]  lda_colour;
    state_t      dbg_state;

    lda_avalon_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .lda_go      (lda_go),
        .lda_done    (lda_done),
        .lda_x0      (lda_x0),
        .lda_x1      (lda_x1),
        .lda_y0      (lda_y0),
        .lda_y1      (lda_y1),
        .lda_colour  (lda_colour),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // ---------------- register model ----------------
    logic        m_mode;
    logic [8:0]  m_x0, m_x1;
    logic [7:0]  m_y0, m_y1;
    logic [2:0]  m_col;
    logic [15:0] m_linecnt;

    task automatic model_reset();
        m_mode = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_col = 0; m_linecnt = 0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            ADDR_MODE:    m_mode = d[0];
            ADDR_START:   begin m_x0 = d[8:0]; m_y0 = d[16:9]; end
            ADDR_END:     begin m_x1 = d[8:0]; m_y1 = d[16:9]; end
            ADDR_COLOUR:  m_col = d[2:0];
            ADDR_LINECNT: m_linecnt = 0;
            ADDR_GO: begin
                exp_q.push_back({m_col, m_y1, m_x1, m_y0, m_x0});
                m_linecnt = m_linecnt + 16'd1;
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            ADDR_MODE:    return {31'b0, m_mode};
            ADDR_START:   return {15'b0, m_y0, m_x0};
            ADDR_END:     return {15'b0, m_y1, m_x1};
            ADDR_COLOUR:  return {29'b0, m_col};
            ADDR_LINECNT: return {16'b0, m_linecnt};
            default:      return 32'b0;
        endcase
    endfunction

    // ---------------- engine model ----------------
    int eng_delay  = 4;
    bit eng_stuck  = 0;
    int fell_cyc   = 0;
    int lines_seen = 0;

    initial begin
        int cnt;
        logic prev_go;
        logic [36:0] e;
        lda_done = 0; cnt = 0; prev_go = 0;
        forever begin
            @(posedge clock); #2;
            if (reset) begin
                lda_done = 0; cnt = 0; prev_go = 0;
            end else begin
                if (lda_go && !prev_go) begin
                    lines_seen++;
                    cnt = 0;
                    check_eq("line_queued", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("line_coords", {lda_colour, lda_y1, lda_x1, lda_y0, lda_x0}, e);
                    end
                end
                prev_go = lda_go;
                if (eng_stuck) begin
                    lda_done = 1;
                end else if (lda_go && !lda_done) begin
                    cnt++;
                    if (cnt >= eng_delay) lda_done = 1;
                end else if (!lda_go && lda_done) begin
                    lda_done = 0;
                    fell_cyc = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit         watch_en = 0;
    logic [8:0] watch_x1;
    int         done_cyc;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic also_read,
                             output int waits);
        @(negedge clock);
        chipselect = 1; write = 1; read = also_read; address = a; writedata = d;
        waits = 0;
        #1;
        while (waitrequest && waits < 400) begin
            if (watch_en) check_eq("x1_frozen", lda_x1, watch_x1);
            @(negedge clock); #1;
            waits++;
        end
        check_eq("wr_complete", waitrequest, 0);
        if (also_read) check_eq("rdwr_readdata", readdata, 0);
        done_cyc = cyc;
        @(posedge clock); #1;
        chipselect = 0; write = 0; read = 0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, output int waits);
        if (a == ADDR_GO) model_write(a, d);
        bus_write(a, d, 1'b0, waits);
        if (a != ADDR_GO) model_write(a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clock);
        chipselect = 1; read = 1; write = 0; address = a;
        #1;
        d = readdata;
        check_eq("rd_nowait", waitrequest, 0);
        @(posedge clock); #1;
        chipselect = 0; read = 0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        int quiet = 0;
        while (quiet < 2 && n < 2000) begin
            @(negedge clock);
            n++;
            if (!lda_go && !lda_done) quiet++;
            else quiet = 0;
        end
        check_eq("idle_reached", quiet >= 2, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int ls0;
        logic [2:0] ra;
        logic [2:0] rd_addrs[6];
        rd_addrs[0] = ADDR_MODE;  rd_addrs[1] = ADDR_GO;     rd_addrs[2] = ADDR_START;
        rd_addrs[3] = ADDR_END;   rd_addrs[4] = ADDR_COLOUR; rd_addrs[5] = 3'd7;

        reset = 1; chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
        model_reset();
        repeat (3) @(negedge clock);
        check_eq("rst_go", lda_go, 0);
        check_eq("rst_wait", waitrequest, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        reset = 0;
        for (int a = 0; a < 8; a++) read_check("rst_reg", 3'(a), 32'h0);

        // poll mode line
        do_write(ADDR_MODE, 32'h1, w);
        do_write(ADDR_START, 32'h0000A, w);
        do_write(ADDR_END, (32'd20 << 9) | 32'd50, w);
        do_write(ADDR_COLOUR, 32'h5, w);
        check_eq("poll_x0", lda_x0, 10);
        check_eq("poll_y0", lda_y0, 0);
        check_eq("poll_x1", lda_x1, 50);
        check_eq("poll_y1", lda_y1, 20);
        eng_delay = 40;
        do_write(ADDR_GO, 32'h0, w);
        check_eq("poll_go_nowait", w, 0);
        @(negedge clock);
        check_eq("poll_go_next", lda_go, 1);
        read_check("poll_status", ADDR_STATUS, 32'h1);
        repeat (20) @(negedge clock);
        check_eq("poll_go_hold", lda_go, 1);
        read_check("poll_status_hold", ADDR_STATUS, 32'h1);
        wait_idle();
        read_check("poll_status_idle", ADDR_STATUS, 32'h0);
        read_check("poll_linecnt", ADDR_LINECNT, model_read(ADDR_LINECNT));

        // stall mode line
        do_write(ADDR_MODE, 32'h0, w);
        eng_delay = 10;
        do_write(ADDR_GO, 32'h0, w);
        check_eq("stall_waited", w > 10, 1);
        check_eq("stall_release_cyc", done_cyc, fell_cyc + 1);
        check_eq("stall_go_low", lda_go, 0);
        read_check("stall_status", ADDR_STATUS, 32'h0);
        read_check("stall_linecnt", ADDR_LINECNT, model_read(ADDR_LINECNT));

        // register write while busy
        do_write(ADDR_MODE, 32'h1, w);
        eng_delay = 30;
        do_write(ADDR_GO, 32'h0, w);
        watch_en = 1; watch_x1 = m_x1;
        do_write(ADDR_END, 32'h1FF, w);
        watch_en = 0;
        check_eq("busy_wr_stalled", w > 0, 1);
        check_eq("busy_wr_x1", lda_x1, 511);
        check_eq("busy_wr_y1", lda_y1, 0);
        read_check("busy_wr_end", ADDR_END, model_read(ADDR_END));

        // back-to-back GO in poll mode
        eng_delay = 6;
        ls0 = lines_seen;
        do_write(ADDR_GO, 32'h0, w);
        check_eq("b2b_first_nowait", w, 0);
        do_write(ADDR_GO, 32'h0, w);
        check_eq("b2b_second_stall", w > 0, 1);
        wait_idle();
        check_eq("b2b_lines", lines_seen - ls0, 2);
        read_check("b2b_linecnt", ADDR_LINECNT, model_read(ADDR_LINECNT));

        // line counter wrap
        force dut.r_linecnt = 16'hFFFF;
        @(posedge clock); #1;
        release dut.r_linecnt;
        m_linecnt = 16'hFFFF;
        read_check("wrap_pre", ADDR_LINECNT, 32'hFFFF);
        do_write(ADDR_GO, 32'h0, w);
        wait_idle();
        read_check("wrap_post", ADDR_LINECNT, model_read(ADDR_LINECNT));

        // decode corner cases
        read_check("dec_addr7", 3'd7, 32'h0);
        read_check("dec_go_ro", ADDR_GO, 32'h0);
        do_write(ADDR_START, 32'hFFFF_FFFF, w);
        read_check("dec_start_trunc", ADDR_START, 32'h1FFFF);
        do_write(ADDR_COLOUR, 32'hFFFF_FFFE, w);
        read_check("dec_colour_trunc", ADDR_COLOUR, model_read(ADDR_COLOUR));
        bus_write(ADDR_COLOUR, 32'h3, 1'b1, w);
        model_write(ADDR_COLOUR, 32'h3);
        read_check("dec_rdwr_is_write", ADDR_COLOUR, 32'h3);
        do_write(ADDR_LINECNT, 32'h1234, w);
        read_check("dec_linecnt_clear", ADDR_LINECNT, 32'h0);
        @(negedge clock);
        chipselect = 0; read = 1; address = ADDR_MODE; #1;
        check_eq("dec_no_cs", readdata, 0);
        read = 0;

        // done stuck high while idle
        eng_stuck = 1;
        repeat (2) @(negedge clock);
        do_write(ADDR_GO, 32'h0, w);
        @(negedge clock);
        check_eq("stuck_go_pulse", lda_go, 1);
        @(negedge clock);
        check_eq("stuck_go_drop", lda_go, 0);
        repeat (5) @(negedge clock);
        read_check("stuck_status", ADDR_STATUS, 32'h1);
        eng_stuck = 0;
        wait_idle();
        read_check("stuck_linecnt", ADDR_LINECNT, model_read(ADDR_LINECNT));

        // reset in the middle of a line
        eng_delay = 50;
        do_write(ADDR_START, 32'h1_2345, w);
        do_write(ADDR_GO, 32'h0, w);
        repeat (5) @(negedge clock);
        reset = 1;
        #1;
        check_eq("midrst_go", lda_go, 0);
        check_eq("midrst_state", dbg_state, ST_IDLE);
        repeat (2) @(negedge clock);
        reset = 0;
        model_reset();
        read_check("midrst_status", ADDR_STATUS, 32'h0);
        read_check("midrst_start", ADDR_START, 32'h0);
        read_check("midrst_end", ADDR_END, 32'h0);
        read_check("midrst_colour", ADDR_COLOUR, 32'h0);
        read_check("midrst_linecnt", ADDR_LINECNT, 32'h0);
        read_check("midrst_mode", ADDR_MODE, 32'h0);

        // randomized traffic against the register model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0: do_write(ADDR_MODE, $urandom, w);
                1: do_write(ADDR_START, $urandom, w);
                2: do_write(ADDR_END, $urandom, w);
                3: do_write(ADDR_COLOUR, $urandom, w);
                4: begin
                    if ($urandom_range(0, 3) == 0) do_write(ADDR_LINECNT, $urandom, w);
                end
                5, 6: begin
                    eng_delay = $urandom_range(2, 8);
                    if (m_mode == 1'b0) begin
                        do_write(ADDR_GO, $urandom, w);
                        check_eq("rnd_stall_go", w > 0, 1);
                    end else begin
                        do_write(ADDR_GO, $urandom, w);
                    end
                end
                7, 8: begin
                    ra = rd_addrs[$urandom_range(0, 5)];
                    read_check("rnd_read", ra, model_read(ra));
                end
                default: begin
                    wait_idle();
                    read_check("rnd_status", ADDR_STATUS, 32'h0);
                    read_check("rnd_linecnt", ADDR_LINECNT, model_read(ADDR_LINECNT));
                end
            endcase
        end
        wait_idle();
        read_check("end_linecnt", ADDR_LINECNT, model_read(ADDR_LINECNT));
        check_eq("lines_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
